// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and tx arbiter state encoding (UART_ARB_TAG_EN adds tag states)
package uart_pkg;

    localparam int BPS      = 9600;
    localparam int UART_CLK = BPS * 16;

    localparam logic [7:0] TAG_BASE_DEFAULT = 8'hA0;

`ifdef UART_ARB_TAG_EN
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_TAG  = 3'd1,
        ST_WAIT_TAG  = 3'd2,
        ST_SEND_DATA = 3'd3,
        ST_WAIT_DATA = 3'd4
    } arb_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_DATA = 3'd3,
        ST_WAIT_DATA = 3'd4
    } arb_state_e;
`endif

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter starting after the last grant
module rr_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [2:0]        last_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [2:0]        gnt_idx_o,
    output logic              gnt_valid_o
);

    always_comb begin
        int idx;
        idx         = 0;
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        // Offset 1..NUM_CH so the previous winner is considered last.
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = (int'(last_i) + k) % NUM_CH;
            if (!gnt_valid_o && req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = 3'(idx);
                gnt_o[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter feeding one shared UART transmitter (UART_ARB_TAG_EN: tag byte first)
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int         NUM_CH   = 4,
    parameter logic [7:0] TAG_BASE = TAG_BASE_DEFAULT
) (
    input  logic                  uart_clk,
    input  logic                  rst_n,
    input  logic [NUM_CH-1:0]     req,
    input  logic [8*NUM_CH-1:0]   req_data,
    output logic [NUM_CH-1:0]     ack,
    output logic [7:0]            tx_data,
    output logic                  tx_en,
    input  logic                  tx_done,
    output logic                  busy,
    output logic [2:0]            grant_id
);

    arb_state_e        state_q, state_d;
    logic [2:0]        grant_q, grant_d;
    logic [2:0]        last_q, last_d;
    logic [7:0]        data_q, data_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_en_q, tx_en_d;
    logic              busy_q, busy_d;
    logic [NUM_CH-1:0] ack_q, ack_d;

    logic [NUM_CH-1:0] gnt_onehot;
    logic [2:0]        gnt_idx;
    logic              gnt_valid;
    logic [7:0]        win_data;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_rr_arbiter (
        .req_i       (req),
        .last_i      (last_q),
        .gnt_o       (gnt_onehot),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    always_comb begin
        win_data = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            win_data = win_data | (req_data[8*i +: 8] & {8{gnt_onehot[i]}});
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        data_d    = data_q;
        tx_data_d = tx_data_q;
        tx_en_d   = 1'b0;
        ack_d     = '0;
        case (state_q)
            ST_IDLE: begin
                // The ack cycle is skipped so a just-served requester can drop req first.
                if (gnt_valid && !(|ack_q)) begin
                    grant_d = gnt_idx;
                    last_d  = gnt_idx;
                    data_d  = win_data;
                    tx_en_d = 1'b1;
`ifdef UART_ARB_TAG_EN
                    state_d   = ST_SEND_TAG;
                    tx_data_d = TAG_BASE | {5'b00000, gnt_idx};
`else
                    state_d   = ST_SEND_DATA;
                    tx_data_d = win_data;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            ST_SEND_TAG: state_d = ST_WAIT_TAG;
            ST_WAIT_TAG: begin
                if (tx_done) begin
                    state_d   = ST_SEND_DATA;
                    tx_en_d   = 1'b1;
                    tx_data_d = data_q;
                end
            end
`endif
            ST_SEND_DATA: state_d = ST_WAIT_DATA;
            ST_WAIT_DATA: begin
                if (tx_done) begin
                    state_d = ST_IDLE;
                    for (int i = 0; i < NUM_CH; i++) begin
                        ack_d[i] = (grant_q == 3'(i));
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE) || (|ack_d);
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= 3'd0;
            last_q    <= 3'(NUM_CH - 1);
            data_q    <= 8'h00;
            tx_data_q <= 8'h00;
            tx_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            data_q    <= data_d;
            tx_data_q <= tx_data_d;
            tx_en_q   <= tx_en_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
        end
    end

    assign ack      = ack_q;
    assign tx_data  = tx_data_q;
    assign tx_en    = tx_en_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NUM_CH, default 4: number of requester channels (2..8).
REQ-002 Parameter TAG_BASE, default 8'hA0: upper bits of the channel tag byte (channel id ORed into bits [2:0]).
REQ-003 Port uart_clk  input  1: the single clock, 16x baud domain shared with the UART receiver/transmitter.
REQ-004 Port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 Port req  input  NUM_CH: per-channel request to send one byte; held high until ack.
REQ-006 Port req_data  input  8*NUM_CH: byte for channel i on bits [8i+7:8i]; stable while req[i] high.
REQ-007 Port ack  output  NUM_CH: one-cycle pulse, byte of that channel fully transmitted.
REQ-008 Port tx_data  output  8: byte to shared UART transmitter.
REQ-009 Port tx_en  output  1: one-cycle start pulse to transmitter.
REQ-010 Port tx_done  input  1: one-cycle pulse from transmitter, current byte (incl. stop bit) finished.
REQ-011 Port busy  output  1: high from grant until the ack cycle inclusive.
REQ-012 Port grant_id  output  3: index of currently granted channel; holds last value when idle.

Function
REQ-013 States: IDLE, SEND_TAG, WAIT_TAG, SEND_DATA, WAIT_DATA; all registered outputs.
REQ-014 IDLE: if any req bit high at a clock edge, register winner into grant_id, latch its req_data, go to SEND_TAG (tag build) or SEND_DATA (otherwise).
REQ-015 Arbitration round-robin: search starts at (last_grant+1) mod NUM_CH; after reset last_grant = NUM_CH-1 so channel 0 wins first.
REQ-016 SEND_x: tx_en=1 for exactly one cycle with tx_data valid that cycle; next state WAIT_x.
REQ-017 tx_data holds its value from the tx_en cycle until the matching tx_done.
REQ-018 WAIT_TAG + tx_done -> SEND_DATA; WAIT_DATA + tx_done -> IDLE with ack[grant_id]=1 that same cycle-edge output (one cycle).
REQ-019 Latency: req sampled in IDLE at edge N -> tx_en high in cycle N+1; ack -> earliest next tx_en two cycles later (IDLE re-arbitrates one cycle).
REQ-020 tx_done in IDLE or SEND_x is ignored.
REQ-021 Dropping req[i] after grant does not abort: transfer completes, ack still pulses.
REQ-022 Simultaneous requests: only one grant per transaction; losers wait, never acked early.
REQ-023 At most one ack bit high in any cycle; ack never coincides with tx_en.

Reset
REQ-024 On rst_n low, immediately: state IDLE, ack=0, tx_en=0, tx_data=8'h00, busy=0, grant_id=0, last_grant=NUM_CH-1.
REQ-025 Reset mid-transfer abandons it without ack; first grant after release follows REQ-015.

Configuration
REQ-026 Macro UART_ARB_TAG_EN defined: each grant sends tag byte TAG_BASE|grant_id then data byte (SEND_TAG/WAIT_TAG used).
REQ-027 Macro undefined: SEND_TAG/WAIT_TAG not compiled; grant sends only the data byte; TAG_BASE unused.

Structure
REQ-028 Shared package uart_pkg holds the state enum/encoding constants, BPS 9600, UART_CLK = BPS*16, and TAG_BASE default.
REQ-029 One sub-module rr_arbiter (NUM_CH requests, last_grant in, one-hot + index grant out, combinational); the FSM stays in uart_tx_arb.

Verification
REQ-030 Single req[0], data 8'h55, tag off: tx_en one cycle later with tx_data=8'h55; tx_done after 10 bit times -> ack[0] one cycle, busy low next.
REQ-031 Tag on, req[2] data 8'h3C: tx_data sequence 8'hA2 then 8'h3C, two tx_en pulses, single ack[2] after second tx_done.
REQ-032 req=4'b1111 from reset, held: grants in order 0,1,2,3,0; one ack per byte, never overlapping.
REQ-033 req[1] dropped one cycle after grant: byte still sent, ack[1] pulses; spurious tx_done in IDLE -> no state change.
REQ-034 rst_n low during WAIT_DATA: outputs to reset values asynchronously, no ack; after release req[3] alone granted normally.
REQ-035 Receiver loopback: feed 8'h55 via uart_rxd at 9600 baud, fr_wrreq-driven req[0] -> transmitter line reproduces 8'h55.
